// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds PC/IR, one imem read per instruction, presents op/operand.
// Latency: instr_valid one cycle after imem_ready; backpressure: FETCH waits on imem_ready, ISSUE waits on ex_done.
module fetch_unit #(
  parameter int IW       = 16,
  parameter int PC_W     = 12,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [IW-1:0]   imem_rdata,
  output logic [3:0]      op,
  output logic [IW-5:0]   operand,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc,
  input  logic            jump,
  input  logic            branch,
  input  logic            acc_zero,
  input  logic            ex_done
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic            req_q, req_d;
  logic            vld_q, vld_d;
  logic [PC_W-1:0] next_pc;

  // Jump and taken branch share the same target field, so jump priority is implicit.
  always_comb begin
    next_pc = pc_q + 1'b1;
    if (jump || (branch && acc_zero)) begin
      next_pc = ir_q[PC_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    req_d   = req_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
      end
      FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = ISSUE;
          req_d   = 1'b0;
          vld_d   = 1'b1;
        end
      end
      ISSUE: begin
        if (ex_done) begin
          pc_d    = next_pc;
          state_d = FETCH;
          req_d   = 1'b1;
          vld_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= PC_W'(RESET_PC);
      ir_q    <= '0;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      req_q   <= req_d;
      vld_q   <= vld_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_valid = vld_q;
  assign op          = ir_q[IW-1:IW-4];
  assign operand     = ir_q[IW-5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, wait states, jump, branch, wrap, async reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic [3:0]  op;
  logic [11:0] operand;
  logic        instr_valid;
  logic [11:0] pc;
  logic        jump, branch, acc_zero, ex_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.IW(16), .PC_W(12), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .op(op), .operand(operand), .instr_valid(instr_valid), .pc(pc),
    .jump(jump), .branch(branch), .acc_zero(acc_zero), .ex_done(ex_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; waits (bounded) for a fetch request and checks its address.
  task automatic wait_fetch(input logic [11:0] addr);
    int n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fetch_req", 32'(imem_req), 32'd1);
    check("fetch_addr", 32'(imem_addr), 32'(addr));
    check("fetch_no_valid", 32'(instr_valid), 32'd0);
  endtask

  // Serve one fetch after 'waits' stall cycles; ex_done/jump noise during FETCH must be ignored.
  task automatic fetch(input logic [11:0] addr, input logic [15:0] word, input int waits);
    wait_fetch(addr);
    for (int i = 0; i < waits; i++) begin
      imem_ready = 1'b0;
      ex_done    = 1'b1;
      jump       = 1'b1;
      @(negedge clk);
      check("stall_req", 32'(imem_req), 32'd1);
      check("stall_addr", 32'(imem_addr), 32'(addr));
      check("stall_valid", 32'(instr_valid), 32'd0);
    end
    ex_done    = 1'b0;
    jump       = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = 16'h0000;
    check("issue_valid", 32'(instr_valid), 32'd1);
    check("issue_req_low", 32'(imem_req), 32'd0);
    check("issue_op", 32'(op), 32'(word[15:12]));
    check("issue_operand", 32'(operand), 32'(word[11:0]));
    check("issue_pc", 32'(pc), 32'(addr));
  endtask

  // Hold ISSUE for 'delay' cycles (with stray imem_ready), then complete with decoder flags.
  task automatic exec(input logic j, input logic b, input logic z, input int delay,
                      input logic [15:0] word);
    for (int i = 0; i < delay; i++) begin
      imem_ready = 1'b1;
      imem_rdata = 16'hFFFF;
      @(negedge clk);
      check("hold_valid", 32'(instr_valid), 32'd1);
      check("hold_op", 32'(op), 32'(word[15:12]));
      check("hold_operand", 32'(operand), 32'(word[11:0]));
    end
    imem_ready = 1'b0;
    imem_rdata = 16'h0000;
    jump       = j;
    branch     = b;
    acc_zero   = z;
    ex_done    = 1'b1;
    @(negedge clk);
    ex_done  = 1'b0;
    jump     = 1'b0;
    branch   = 1'b0;
    acc_zero = 1'b0;
    check("done_valid_low", 32'(instr_valid), 32'd0);
    check("done_req", 32'(imem_req), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(imem_req), 32'd0);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_pc"}, 32'(pc), 32'd0);
    check({tag, "_op"}, 32'(op), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    imem_ready = 1'b0; imem_rdata = 16'h0000;
    jump = 1'b0; branch = 1'b0; acc_zero = 1'b0; ex_done = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Sequential: 0 -> 1 -> 2
    fetch(12'h000, 16'h4005, 0);
    exec(1'b0, 1'b0, 1'b0, 0, 16'h4005);
    fetch(12'h001, 16'h8003, 0);
    exec(1'b0, 1'b0, 1'b0, 0, 16'h8003);
    // Jump to 0xABC, branch also high with acc_zero low: jump still wins
    fetch(12'h002, 16'h1ABC, 0);
    exec(1'b1, 1'b1, 1'b0, 0, 16'h1ABC);
    fetch(12'hABC, 16'h1007, 0);
    exec(1'b1, 1'b0, 1'b0, 0, 16'h1007);
    // Wait states at pc=7, then jump to 5
    fetch(12'h007, 16'h1005, 4);
    exec(1'b1, 1'b0, 1'b0, 0, 16'h1005);
    // Taken branch at pc=5
    fetch(12'h005, 16'h9020, 0);
    exec(1'b0, 1'b1, 1'b1, 0, 16'h9020);
    fetch(12'h020, 16'h1005, 0);
    exec(1'b1, 1'b0, 1'b0, 0, 16'h1005);
    // Not-taken branch at pc=5 falls through to 6
    fetch(12'h005, 16'h9020, 0);
    exec(1'b0, 1'b1, 1'b0, 0, 16'h9020);
    fetch(12'h006, 16'h1FFF, 0);
    exec(1'b1, 1'b0, 1'b0, 0, 16'h1FFF);
    // Wrap from 0xFFF with a 5-cycle execute stall
    fetch(12'hFFF, 16'h3000, 0);
    exec(1'b0, 1'b0, 1'b0, 5, 16'h3000);
    // NOP advances like any instruction
    fetch(12'h000, 16'h0000, 0);
    exec(1'b0, 1'b0, 1'b0, 0, 16'h0000);
    // Reset mid-issue
    fetch(12'h001, 16'h5123, 0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_issue");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fetch(12'h000, 16'h4005, 0);
    exec(1'b0, 1'b0, 1'b0, 0, 16'h4005);
    // Reset mid-fetch
    wait_fetch(12'h001);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_fetch");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wait_fetch(12'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
